cfg_region_lookup: RTL and testbench



---
 rtl/cfg_region_pkg.sv | 21 ++
 rtl/cfg_region_match.sv | 19 +
 rtl/cfg_region_lookup.sv | 163 ++++++++++++++++
 tb/tb_cfg_region_lookup.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_region_pkg.sv
// rtl/cfg_region_pkg.sv - shared types, sizes and rule-table accessors for cfg_region_lookup
package cfg_region_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } region_state_e;

  localparam int MaxRules = 16;
  localparam int RuleIdxW = 4;

  function automatic logic [63:0] rule_base(input logic [1023:0] vec, input int i);
    return vec[64*i +: 64];
  endfunction

  function automatic logic [63:0] rule_len(input logic [1023:0] vec, input int i);
    return vec[64*i +: 64];
  endfunction

endpackage

// File: rtl/cfg_region_match.sv
// rtl/cfg_region_match.sv - single-rule comparator: base <= addr < base+len, zero length never matches
module cfg_region_match (
  input  logic [63:0] addr,
  input  logic [63:0] base,
  input  logic [63:0] len,
  output logic        match
);

  logic [64:0] addr_ext;
  logic [64:0] base_ext;
  logic [64:0] limit;

  // One extra bit keeps base+len from wrapping at the top of the address space.
  assign addr_ext = {1'b0, addr};
  assign base_ext = {1'b0, base};
  assign limit    = base_ext + {1'b0, len};
  assign match    = (len != 64'd0) && (addr_ext >= base_ext) && (addr_ext < limit);

endmodule

// File: rtl/cfg_region_lookup.sv
// rtl/cfg_region_lookup.sv - sequential region classifier, one rule per cycle, lowest index wins
// Optional last-hit shortcut enabled by defining CFG_REGION_LOOKUP_CACHE_EN.
module cfg_region_lookup
  import cfg_region_pkg::*;
#(
  parameter int             NrRules      = 3,
  parameter int             AddrWidth    = 64,
  parameter logic [1023:0]  RuleAddrBase = 1024'({64'h8000_0000, 64'h1_0000, 64'h0}),
  parameter logic [1023:0]  RuleLength   = 1024'({64'h40000000, 64'h10000, 64'h1000})
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [RuleIdxW-1:0]  rsp_idx_o,
  output logic                 busy_o
);

  localparam logic [RuleIdxW-1:0] LastIdx = RuleIdxW'(NrRules - 1);

  region_state_e       state, state_next;
  logic [63:0]         addr;
  logic [63:0]         req_addr_ext;
  logic [RuleIdxW-1:0] idx;
  logic [RuleIdxW-1:0] rsp_idx;
  logic                hit;
  logic                accept;
  logic                scan_match;
  logic                scan_last;
  logic [63:0]         scan_base;
  logic [63:0]         scan_len;
  logic                cache_take;
  logic [RuleIdxW-1:0] cache_idx;

  assign req_addr_ext = 64'(req_addr_i);
  assign accept       = req_valid_i && req_ready_o;
  assign scan_base    = rule_base(RuleAddrBase, int'(idx));
  assign scan_len     = rule_len(RuleLength, int'(idx));
  assign scan_last    = (idx == LastIdx);

  cfg_region_match u_scan_match (
    .addr  (addr),
    .base  (scan_base),
    .len   (scan_len),
    .match (scan_match)
  );

`ifdef CFG_REGION_LOOKUP_CACHE_EN
  logic        cache_valid;
  logic        cache_match;
  logic [63:0] cache_base;
  logic [63:0] cache_len;

  assign cache_base = rule_base(RuleAddrBase, int'(cache_idx));
  assign cache_len  = rule_len(RuleLength, int'(cache_idx));
  assign cache_take = cache_valid && cache_match;

  cfg_region_match u_cache_match (
    .addr  (req_addr_ext),
    .base  (cache_base),
    .len   (cache_len),
    .match (cache_match)
  );

  // The shortcut only returns the lowest matching index if no two rules overlap.
  for (genvar i = 0; i < NrRules; i++) begin : g_ovl_i
    for (genvar j = i + 1; j < NrRules; j++) begin : g_ovl_j
      localparam logic [64:0] BaseI = {1'b0, RuleAddrBase[64*i +: 64]};
      localparam logic [64:0] LenI  = {1'b0, RuleLength[64*i +: 64]};
      localparam logic [64:0] BaseJ = {1'b0, RuleAddrBase[64*j +: 64]};
      localparam logic [64:0] LenJ  = {1'b0, RuleLength[64*j +: 64]};
      if (LenI != 65'd0 && LenJ != 65'd0 && BaseI < BaseJ + LenJ && BaseJ < BaseI + LenI) begin : g_err
        $error("cfg_region_lookup: overlapping rules with cache enabled");
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid <= 1'b0;
      cache_idx   <= '0;
    end else if (flush_i) begin
      cache_valid <= 1'b0;
    end else if (state == SCAN) begin
      if (scan_match) begin
        cache_valid <= 1'b1;
        cache_idx   <= idx;
      end else if (scan_last) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  assign cache_take = 1'b0;
  assign cache_idx  = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = cache_take ? RESP : SCAN;
        SCAN:    if (scan_match || scan_last) state_next = RESP;
        RESP:    if (rsp_ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr    <= '0;
      idx     <= '0;
      hit     <= 1'b0;
      rsp_idx <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr    <= req_addr_ext;
            idx     <= '0;
            hit     <= cache_take;
            rsp_idx <= cache_take ? cache_idx : '0;
          end
        end
        SCAN: begin
          if (scan_match) begin
            hit     <= 1'b1;
            rsp_idx <= idx;
          end else if (scan_last) begin
            hit     <= 1'b0;
            rsp_idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign rsp_valid_o = (state == RESP);
  assign rsp_hit_o   = hit;
  assign rsp_idx_o   = rsp_idx;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_cfg_region_lookup.sv
// tb/tb_cfg_region_lookup.sv - scoreboard bench for cfg_region_lookup with default rule table
module tb_cfg_region_lookup;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    int         lat;
    int         acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [3:0]  rsp_idx;
  logic        busy;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   in_rsp = 0;

`ifdef CFG_REGION_LOOKUP_CACHE_EN
  localparam int CachedLat = 1;
`else
  localparam int CachedLat = 4;
`endif
`ifdef CFG_REGION_LOOKUP_CACHE_EN
  localparam int CachedLat0 = 1;
`else
  localparam int CachedLat0 = 2;
`endif

  cfg_region_lookup dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_hit_o   (rsp_hit),
    .rsp_idx_o   (rsp_idx),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: score each response once, when it first appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !in_rsp) begin
        in_rsp = 1;
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_rsp: got hit=%0d idx=%0d expected no response", rsp_hit, rsp_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
          chk("rsp_idx", 64'(rsp_idx), 64'(e.idx));
          chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      if (rsp_valid && rsp_ready) in_rsp = 0;
    end
  end

  task automatic do_req(input logic [63:0] a, input logic h, input logic [3:0] i,
                        input int lat, input bit push);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("req_accept_timeout", 64'd0, 64'd1);
    else if (push) sb.push_back('{hit: h, idx: i, lat: lat, acc: cyc});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && !in_rsp && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_hit", 64'(rsp_hit), 64'd0);
    chk("rst_rsp_idx", 64'(rsp_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    do_req(64'h0000_0FFF, 1'b1, 4'd0, 2, 1); wait_done();
    do_req(64'h0000_1000, 1'b0, 4'd0, 4, 1); wait_done();
    do_req(64'h8000_0000, 1'b1, 4'd2, 4, 1); wait_done();
    do_req(64'hC000_0000, 1'b0, 4'd0, 4, 1); wait_done();
    do_req(64'h0001_FFFF, 1'b1, 4'd1, 3, 1); wait_done();
    do_req(64'h0002_0000, 1'b0, 4'd0, 4, 1); wait_done();

    // Backpressure: response must hold still while the consumer stalls.
    rsp_ready = 1'b0;
    do_req(64'h8000_0000, 1'b1, 4'd2, 4, 1);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          seen = 1;
          break;
        end
      end
      if (!seen) chk("bp_rsp_timeout", 64'd0, 64'd1);
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_hit", 64'(rsp_hit), 64'd1);
      chk("bp_rsp_idx", 64'(rsp_idx), 64'd2);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_req_ready", 64'(req_ready), 64'd1);
    chk("bp_release_rsp_valid", 64'(rsp_valid), 64'd0);
    wait_done();

    // A request alongside flush in IDLE must not be taken.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 64'h0;
    flush     = 1'b1;
    @(negedge clk);
    chk("flush_idle_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);

    // Flush on the second scan cycle drops the lookup.
    do_req(64'h8000_0000, 1'b1, 4'd2, 4, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_scan_busy", 64'(busy), 64'd0);
    chk("flush_scan_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (4) @(negedge clk);
    do_req(64'h0001_0000, 1'b1, 4'd1, 3, 1); wait_done();

    // Repeat hits in one region; shortcut latency applies when the cache is built in.
    do_req(64'h8000_0000, 1'b1, 4'd2, 4, 1); wait_done();
    do_req(64'h8000_1000, 1'b1, 4'd2, CachedLat, 1); wait_done();
    do_req(64'h0000_0000, 1'b1, 4'd0, 2, 1); wait_done();
    do_req(64'h0000_0010, 1'b1, 4'd0, CachedLat0, 1); wait_done();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
